mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning the log2 of the word depth of the internal data array (1024 words).
REQ-002 The block SHALL have parameter WAIT, default 2, legal range 1..15, meaning the number of BUSY cycles per access.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port memen, input, 1 bit: the memory-stage request strobe.
REQ-006 The block SHALL have port memwe, input, 1 bit: 1 for a write, 0 for a read.
REQ-007 The block SHALL have port size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 The block SHALL have port addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata, input, 32 bits: write data, right-justified.
REQ-010 The block SHALL have port rdata, output, 32 bits: the full aligned word read.
REQ-011 The block SHALL have port stall, output, 1 bit: holds the pipeline while high.
REQ-012 The block SHALL have port err, output, 1 bit: flags an access that was rejected.

Function
REQ-013 The block SHALL implement the FSM states IDLE, BUSY and DONE, plus a 4-bit wait counter cnt.
REQ-014 In IDLE with memen=1, the block SHALL assert stall combinationally, latch memwe/size/addr/wdata, load cnt<=WAIT-1 and go to BUSY.
REQ-015 In IDLE with memen=0, the block SHALL hold stall=0 and remain in IDLE.
REQ-016 In BUSY, the block SHALL hold stall=1, decrement cnt while cnt!=0, and ignore input changes.
REQ-017 In BUSY with cnt==0, at the clock edge the block SHALL perform the access on the latched fields, update rdata/err, and go to DONE.
REQ-018 In DONE, the block SHALL drive stall=0 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 The stall latency per access SHALL be WAIT+1 cycles, with rdata and err valid in the DONE cycle.
REQ-020 A request still present in the cycle after DONE SHALL be treated as a new request.
REQ-021 For a word access, byte lanes SHALL be 1111.
REQ-022 For a halfword access, byte lanes SHALL be 0011 << addr[1:0].
REQ-023 For a byte access, byte lanes SHALL be 0001 << addr[1:0].
REQ-024 On a write, wdata[7:0] or wdata[15:0] SHALL be placed in the selected lane(s), and only the enabled bytes SHALL change.
REQ-025 On a read, the block SHALL return the full word at addr[AW+1:2]; lane extraction is not performed here.
REQ-026 The block SHALL reject an access as an error when any of the following holds:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- size=11;
- addr[31:AW+2]!=0.
REQ-027 On error, the block SHALL suppress the write, load rdata<=0, and set err=1 in the DONE cycle only.
REQ-028 Outside DONE, err SHALL be 0, and rdata SHALL hold its last loaded value.
REQ-029 A write SHALL be visible to a read issued immediately after it (new request in the cycle after DONE).

Reset
REQ-030 While rst=0, the block SHALL force state=IDLE, cnt=0, rdata=0, err=0, stall=0 and clear the latched request fields asynchronously.
REQ-031 A reset asserted in BUSY SHALL abort the access with no array write.
REQ-032 Array contents SHALL NOT be reset.
REQ-033 After rst deasserts, the first rising edge with memen=1 SHALL start a new access.

Verification
REQ-034 The bench SHALL cover, with WAIT=2: word write addr=0x10, wdata=0xDEADBEEF -> stall high 3 cycles, DONE err=0; a following word read of 0x10 -> rdata=0xDEADBEEF in its DONE cycle.
REQ-035 The bench SHALL cover: byte write addr=0x13, wdata=0x000000AA over 0xDEADBEEF, then word read 0x10 -> rdata=0xAAADBEEF.
REQ-036 The bench SHALL cover: halfword write addr=0x11 -> err=1 in DONE, rdata=0, and a word read of 0x10 shows the word unchanged.
REQ-037 The bench SHALL cover: read addr=0x00001000 (word index 1024, out of range for AW=10) -> err=1, rdata=0.
REQ-038 The bench SHALL cover: word write to 0x20 with rst pulsed low during BUSY -> stall=0 immediately, and a subsequent read of 0x20 returns the pre-write value.
REQ-039 The bench SHALL cover: back-to-back requests with memen held high over 3 accesses -> stall pattern 1,1,1,0 repeated, with each DONE carrying the correct data.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port data memory responder for a pipeline memory stage: every access
// stalls for WAIT+1 cycles, then presents rdata/err for one DONE cycle.
module mem_responder #(
  parameter int AW   = 10,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic        memwe,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        memwe_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [2**AW];

  logic [3:0]    lanes_d;
  logic          bad_d;
  logic [31:0]   wword_d;
  logic [AW-1:0] idx_d;
  logic          access_d;
  logic          wr_en_d;

  always_comb begin
    lanes_d = 4'b0000;
    wword_d = wdata_q;
    case (size_q)
      2'b00: begin
        lanes_d = 4'b0001 << addr_q[1:0];
        wword_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lanes_d = 4'b0011 << addr_q[1:0];
        wword_d = {2{wdata_q[15:0]}};
      end
      2'b10:   lanes_d = 4'b1111;
      default: lanes_d = 4'b0000;
    endcase
    bad_d = (size_q == 2'b11)
         || (size_q == 2'b01 && addr_q[0])
         || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
         || ((addr_q >> (AW + 2)) != 32'd0);
    idx_d    = addr_q[AW+1:2];
    access_d = (state_q == BUSY) && (cnt_q == 4'd0);
    wr_en_d  = access_d && memwe_q && !bad_d;
  end

  // Array has no reset; an async reset during BUSY leaves state_q at IDLE, so no write fires.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes_d[b]) mem_q[idx_d][8*b +: 8] <= wword_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      memwe_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memen) begin
            memwe_q <= memwe;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q <= bad_d ? 32'd0 : mem_q[idx_d];
            err_q   <= bad_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall rises in the request cycle itself so the pipeline freezes without a bubble.
  assign stall = rst && (((state_q == IDLE) && memen) || (state_q == BUSY));
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT=2): expected DONE results are queued
// when each request is driven and compared when the DONE cycle arrives.
module tb_mem_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memen;
  logic        memwe;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  mem_responder #(.AW(10), .WAIT(WAIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .memen (memen),
    .memwe (memwe),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .stall (stall),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One isolated access: memen pulsed for the request cycle only.
  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
    exp_t e;
    int   n;
    logic done;
    sb.push_back('{exp_rd, exp_err, chk_rd});
    @(posedge clk); #1;
    memen = 1'b1; memwe = we; size = sz; addr = a; wdata = wd;
    #1;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      if (stall) begin
        n++;
        @(posedge clk); #1;
        memen = 1'b0;
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stallcyc"}, 32'(n), 32'(WAIT + 1));
    e = sb.pop_front();
    check({tag, "_err"}, 32'(err), 32'(e.er));
    if (e.chk_rd) check({tag, "_rdata"}, rdata, e.rd);
    @(posedge clk); #2;
    check({tag, "_errclr"}, 32'(err), 32'd0);
    if (e.chk_rd) check({tag, "_rdhold"}, rdata, e.rd);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ba [3];
    logic [31:0] bd [3];

    rst = 1'b0; memen = 1'b1; memwe = 1'b0; size = 2'b10; addr = 32'd0; wdata = 32'd0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    memen = 1'b0;
    @(negedge clk); rst = 1'b1;

    access("wr10", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    access("rd10a", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    access("wrb13", 1'b1, 2'b00, 32'h13, 32'h000000AA, 32'h0, 1'b0, 1'b0);
    access("rd10b", 1'b0, 2'b10, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, 1'b1);
    access("wrh11", 1'b1, 2'b01, 32'h11, 32'h00005555, 32'h0, 1'b1, 1'b1);
    access("rd10c", 1'b0, 2'b10, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, 1'b1);
    access("rdoor", 1'b0, 2'b10, 32'h00001000, 32'h0, 32'h0, 1'b1, 1'b1);
    access("wr14", 1'b1, 2'b10, 32'h14, 32'h11223344, 32'h0, 1'b0, 1'b0);
    access("wrh16", 1'b1, 2'b01, 32'h16, 32'hFFFF1234, 32'h0, 1'b0, 1'b0);
    access("rd14", 1'b0, 2'b10, 32'h14, 32'h0, 32'h12343344, 1'b0, 1'b1);
    access("rdsz3", 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
    access("rd14b", 1'b0, 2'b10, 32'h14, 32'h0, 32'h12343344, 1'b0, 1'b1);
    access("rdmis", 1'b0, 2'b10, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1);

    // Reset pulsed during BUSY must abort the write.
    access("pre20", 1'b1, 2'b10, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    access("rd20a", 1'b0, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    @(posedge clk); #1;
    memen = 1'b1; memwe = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    memen = 1'b0;
    #1;
    check("abort_busy_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    access("rd20b", 1'b0, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

    // Back-to-back reads with memen held high.
    ba[0] = 32'h40; ba[1] = 32'h44; ba[2] = 32'h48;
    bd[0] = 32'h01020304; bd[1] = 32'hA5A55A5A; bd[2] = 32'hFEDCBA98;
    for (int k = 0; k < 3; k++)
      access("b2b_wr", 1'b1, 2'b10, ba[k], bd[k], 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) sb.push_back('{bd[k], 1'b0, 1'b1});
    @(posedge clk); #1;
    memen = 1'b1; memwe = 1'b0; size = 2'b10; addr = ba[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      check("b2b_stall", 32'(stall), (cyc % 4 != 3) ? 32'd1 : 32'd0);
      if (cyc % 4 == 3) begin
        e = sb.pop_front();
        check("b2b_rdata", rdata, e.rd);
        check("b2b_err", 32'(err), 32'(e.er));
        if (cyc / 4 < 2) addr = ba[cyc / 4 + 1];
        else memen = 1'b0;
      end
      @(posedge clk); #1;
    end
    #1;
    check("b2b_idle", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
